// File: rtl/useq_sequencer.sv
// useq_sequencer: micro-PC sequencer with dispatch tables, branch, call/return stack and error flags
module useq_sequencer #(
    parameter int AW          = 4,
    parameter int OPW         = 7,
    parameter int NUM_DISP    = 2,
    parameter int STACK_DEPTH = 4,
    parameter int FETCH_ADDR  = 0,
    parameter int DECODE_ADDR = 7,
    localparam int DW  = (NUM_DISP > 1) ? $clog2(NUM_DISP) : 1,
    localparam int SLW = $clog2(STACK_DEPTH + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] op,
    input  logic [2:0]     addr_ctl,
    input  logic [DW-1:0]  disp_sel,
    input  logic [AW-1:0]  branch_target,
    input  logic           cond,
    input  logic           stall,
    input  logic           tbl_we,
    input  logic [DW-1:0]  tbl_sel,
    input  logic [OPW-1:0] tbl_op,
    input  logic [AW:0]    tbl_wdata,
    output logic [AW-1:0]  upc,
    output logic [SLW-1:0] stack_level,
    output logic           dispatch_miss,
    output logic           stack_ovf,
    output logic           stack_unf
);
    localparam int NE = 1 << OPW;
    localparam logic [DW:0]    ND   = (DW + 1)'(NUM_DISP);
    localparam logic [SLW-1:0] FULL = SLW'(STACK_DEPTH);
    localparam logic [AW-1:0]  FA   = AW'(FETCH_ADDR);
    localparam logic [AW-1:0]  DA   = AW'(DECODE_ADDR);
    logic [AW-1:0]  upc_q, upc_d, upc_inc, nxt, top;
    logic [SLW-1:0] lvl_q, lvl_d;
    logic           miss_q, miss_d, ovf_q, ovf_d, unf_q, unf_d;
    logic           hit, miss, push, pop, full, empty;
    logic [AW-1:0]  stk_q [STACK_DEPTH];
    logic [AW-1:0]  stk_d [STACK_DEPTH];
    logic           vld_q [NUM_DISP][NE];
    logic           vld_d [NUM_DISP][NE];
    logic [AW-1:0]  tgt_q [NUM_DISP][NE];
    logic [AW-1:0]  tgt_d [NUM_DISP][NE];
    always_comb begin
        upc_inc = upc_q + AW'(1);
        full    = lvl_q == FULL;
        empty   = lvl_q == '0;
        top     = FA;
        for (int i = 0; i < STACK_DEPTH; i++)
            if (lvl_q == SLW'(i + 1)) top = stk_q[i];
        hit  = ({1'b0, disp_sel} < ND) && vld_q[disp_sel][op];
        nxt  = upc_inc;
        miss = 1'b0;
        push = 1'b0;
        pop  = 1'b0;
        case (addr_ctl)
            3'd1: begin
                nxt  = hit ? tgt_q[disp_sel][op] : FA;
                miss = !hit;
            end
            3'd2: nxt = branch_target;
            3'd3: nxt = FA;
            3'd4: nxt = cond ? branch_target : upc_inc;
            3'd5: begin
                nxt  = branch_target;
                push = 1'b1;
            end
            3'd6: begin
                nxt = top;
                pop = 1'b1;
            end
            3'd7: nxt = DA;
            default: nxt = upc_inc;
        endcase
        upc_d  = stall ? upc_q : nxt;
        miss_d = stall ? miss_q : miss;
        lvl_d  = stall ? lvl_q :
                 (push && !full) ? lvl_q + SLW'(1) :
                 (pop && !empty) ? lvl_q - SLW'(1) : lvl_q;
        ovf_d  = ovf_q | (!stall && push && full);
        unf_d  = unf_q | (!stall && pop && empty);
        stk_d  = stk_q;
        for (int i = 0; i < STACK_DEPTH; i++)
            if (!stall && push && lvl_q == SLW'(i)) stk_d[i] = upc_inc;
        vld_d = vld_q;
        tgt_d = tgt_q;
        if (tbl_we && ({1'b0, tbl_sel} < ND)) begin
            vld_d[tbl_sel][tbl_op] = tbl_wdata[AW];
            tgt_d[tbl_sel][tbl_op] = tbl_wdata[AW-1:0];
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            upc_q  <= FA;
            lvl_q  <= '0;
            miss_q <= 1'b0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            stk_q  <= '{default: '0};
            vld_q  <= '{default: '0};
        end else begin
            upc_q  <= upc_d;
            lvl_q  <= lvl_d;
            miss_q <= miss_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
            stk_q  <= stk_d;
            vld_q  <= vld_d;
        end
    end
    always_ff @(posedge clk) tgt_q <= tgt_d;
    assign upc           = upc_q;
    assign stack_level   = lvl_q;
    assign dispatch_miss = miss_q;
    assign stack_ovf     = ovf_q;
    assign stack_unf     = unf_q;
endmodule

// File: doc/useq_sequencer.md
Name: useq_sequencer

Overview:
- Parametrised microprogram sequencer that owns the micro-PC (uPC) for the multicycle RISC-V control unit.
- Successor to the fixed 4-bit next-address selector.
- Adds the following over that selector:
  - N run-time-writable opcode dispatch tables with valid bits.
  - A conditional micro-branch.
  - A micro-subroutine call/return stack.
  - A stall hold, synchronous reset and error flags.
- Sits between the microcode ROM (which supplies addr_ctl, disp_sel, branch_target and cond) and the ROM address input.

Parameters:
- AW, 4: micro-address width.
- OPW, 7: opcode width.
- NUM_DISP, 2: number of dispatch tables; must be at least 1.
- STACK_DEPTH, 4: return-stack entries; must be at least 1.
- FETCH_ADDR, 0: fetch/restart micro-address.
- DECODE_ADDR, 7: decode micro-address.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high.
- op, input, OPW: opcode of the current instruction.
- addr_ctl, input, 3: next-address control field from the microword.
- disp_sel, input, max(1,$clog2(NUM_DISP)): dispatch table index.
- branch_target, input, AW: jump/branch/call target from the microword.
- cond, input, 1: branch condition (e.g. ALU zero, already qualified).
- stall, input, 1: hold the uPC and stack.
- tbl_we, input, 1: dispatch-table write enable.
- tbl_sel, input, max(1,$clog2(NUM_DISP)): table to write.
- tbl_op, input, OPW: table entry index (opcode).
- tbl_wdata, input, AW+1: entry to write; bit AW = valid, bits [AW-1:0] = target.
- upc, output, AW: current micro-address (registered).
- stack_level, output, $clog2(STACK_DEPTH+1): number of occupied stack entries.
- dispatch_miss, output, 1: one-cycle pulse.
- stack_ovf, output, 1: sticky overflow flag.
- stack_unf, output, 1: sticky underflow flag.

Behaviour:
- Reset (synchronous, active-high, overrides everything including stall and tbl_we):
  - upc = FETCH_ADDR; stack_level = 0.
  - dispatch_miss = 0; stack_ovf = 0; stack_unf = 0.
  - All dispatch entries invalid.
  - Reset asserted mid-operation discards the pending next address and all stack contents.
- Timing:
  - next_upc is combinational from the current upc, addr_ctl, op, cond and stack top.
  - upc <= next_upc on each clk edge when stall=0, giving a latency of one cycle.
- addr_ctl decode:
  - 000 SEQ: upc+1, wrapping modulo 2^AW.
  - 001 DISPATCH: entry = table[disp_sel][op].
    - If entry is valid, go to entry target.
    - Otherwise go to FETCH_ADDR and assert dispatch_miss for the following cycle.
    - disp_sel >= NUM_DISP is treated as an invalid entry.
  - 010 JUMP: branch_target.
  - 011 FETCH: FETCH_ADDR.
  - 100 BRANCH: cond ? branch_target : upc+1.
  - 101 CALL: push upc+1 and go to branch_target.
    - If the stack is full: no push, stack_ovf set, jump still taken.
  - 110 RET: pop and go to the popped address.
    - If the stack is empty: go to FETCH_ADDR, stack_unf set.
  - 111 DECODE: DECODE_ADDR.
- dispatch_miss:
  - Registered; high exactly one cycle after an invalid dispatch is committed.
  - Cleared on any non-miss commit.
- Stall:
  - upc, the stack, stack_level and dispatch_miss hold their values.
  - No push or pop occurs.
  - Table writes still proceed.
- Table write:
  - When tbl_we=1, table[tbl_sel][tbl_op] <= tbl_wdata at the edge; the write is visible from the next cycle.
  - A dispatch and a write to the same entry in the same cycle uses the old contents.
  - tbl_sel >= NUM_DISP makes the write ignored.
- Stack:
  - LIFO; stack_level goes from 0 to STACK_DEPTH.
  - A CALL at level STACK_DEPTH leaves the level unchanged.
  - A RET at level 0 leaves the level at 0.
- Flags: stack_ovf and stack_unf are sticky until reset.

Test Plan:
1. Reset then SEQ ×17 with AW=4 -> upc steps 0,1,…,15,0,1 (wrap); stall=1 for 2 cycles -> upc frozen.
2. Write table0[0x33]=valid|6, table1[0x03]=valid|3, then DISPATCH sel0 with op=0x33 -> upc=6. Next, DISPATCH sel1 with op=0x03 -> upc=3. Next, DISPATCH sel0 with op=0x7F (unwritten) -> upc=0 and dispatch_miss=1 for exactly one cycle.
3. Write to table0[0x13] in the same cycle as DISPATCH sel0 op=0x13 -> miss (old invalid contents). Repeat the dispatch next cycle -> new target.
4. With upc=4: BRANCH target=9 cond=0 -> upc=5; then BRANCH target=9 cond=1 -> upc=9.
5. From upc=2: CALL target=10 -> upc=10, stack_level=1. Then CALL 12 -> level 2. Then RET -> upc=11. Then RET -> upc=3, level 0.
6. STACK_DEPTH=4: 5 consecutive CALLs -> level stays 4 and stack_ovf=1. Then 5 RETs -> 4 correct return addresses, the 5th goes to FETCH_ADDR, stack_unf=1. Assert reset -> all flags 0, upc=0, previously written tables invalid.
